// File: rtl/food_tracker.sv
// food_tracker: latches candidate food coordinates from the food generator,
// tests them against the snake head once per game frame, keeps a two-digit
// BCD score, and requests a new candidate on a hit. A candidate that lands on
// the head is re-rolled up to MAX_RETRY times before being committed.
//
// Ports:
//   VGA_clk     - sole clock, rising edge
//   reset       - synchronous, active-high
//   frame_tick  - one-cycle pulse per game step (only honoured in ACTIVE)
//   head_X/Y    - snake head position in pixels
//   rand_X/Y    - candidate food position from the generator
//   update      - request to the generator (held UPD_HIGH cycles)
//   food_X/Y    - committed food position
//   food_valid  - food placed and drawable
//   ate         - one-cycle pulse on a hit
//   score       - BCD score, [7:4] tens, [3:0] ones
module food_tracker #(
  parameter int unsigned FOOD_SIZE = 10,
  parameter int unsigned UPD_HIGH  = 2,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] head_X,
  input  logic [8:0] head_Y,
  input  logic [9:0] rand_X,
  input  logic [8:0] rand_Y,
  output logic       update,
  output logic [9:0] food_X,
  output logic [8:0] food_Y,
  output logic       food_valid,
  output logic       ate,
  output logic [7:0] score
);

  localparam int unsigned CNT_MAX = (UPD_HIGH > SETTLE) ? UPD_HIGH : SETTLE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    SPAWN  = 2'd0,
    ACTIVE = 2'd1,
    REQ    = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [RW-1:0]   r_retry, w_retry_n;
  logic            r_update, w_update_n;
  logic            r_ate, w_ate_n;
  logic            r_food_valid, w_food_valid_n;
  logic [9:0]      r_food_x, w_food_x_n;
  logic [8:0]      r_food_y, w_food_y_n;
  logic [7:0]      r_score, w_score_n;
  logic            w_spawn_hit, w_active_hit;
  logic [7:0]      w_score_inc;

  // |a-b| < FOOD_SIZE on 10-bit x coordinates, using an 11-bit difference
  function automatic logic near_x(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    logic [10:0] m;
    d = {1'b0, a} - {1'b0, b};
    m = d[10] ? (~d + 11'd1) : d;
    return m < 11'(FOOD_SIZE);
  endfunction

  // |a-b| < FOOD_SIZE on 9-bit y coordinates, using a 10-bit difference
  function automatic logic near_y(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] d;
    logic [9:0] m;
    d = {1'b0, a} - {1'b0, b};
    m = d[9] ? (~d + 10'd1) : d;
    return m < 10'(FOOD_SIZE);
  endfunction

  assign w_spawn_hit  = near_x(head_X, rand_X) && near_y(head_Y, rand_Y);
  assign w_active_hit = near_x(head_X, r_food_x) && near_y(head_Y, r_food_y);

  // BCD increment saturating at 99
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 8'h99) begin
      if (r_score[3:0] == 4'd9) w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      else                      w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_retry_n      = r_retry;
    w_update_n     = r_update;
    w_ate_n        = 1'b0;
    w_food_valid_n = r_food_valid;
    w_food_x_n     = r_food_x;
    w_food_y_n     = r_food_y;
    w_score_n      = r_score;
    case (r_state)
      SPAWN: begin
        if (w_spawn_hit && (r_retry < RW'(MAX_RETRY))) begin
          w_retry_n  = r_retry + RW'(1);
          w_update_n = 1'b1;
          w_cnt_n    = CW'(UPD_HIGH - 1);
          w_state_n  = REQ;
        end else begin
          w_food_x_n     = rand_X;
          w_food_y_n     = rand_Y;
          w_food_valid_n = 1'b1;
          w_retry_n      = '0;
          w_state_n      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_tick && w_active_hit) begin
          w_ate_n        = 1'b1;
          w_food_valid_n = 1'b0;
          w_score_n      = w_score_inc;
          w_update_n     = 1'b1;
          w_cnt_n        = CW'(UPD_HIGH - 1);
          w_state_n      = REQ;
        end
      end
      REQ: begin
        if (r_cnt == '0) begin
          w_update_n = 1'b0;
          w_cnt_n    = CW'(SETTLE - 1);
          w_state_n  = WAIT;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      WAIT: begin
        w_update_n = 1'b0;
        if (r_cnt == '0) w_state_n = SPAWN;
        else             w_cnt_n   = r_cnt - CW'(1);
      end
      default: w_state_n = SPAWN;
    endcase
  end

  // State and output registers
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_state      <= SPAWN;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_update     <= 1'b0;
      r_ate        <= 1'b0;
      r_food_valid <= 1'b0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_score      <= 8'h00;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_retry      <= w_retry_n;
      r_update     <= w_update_n;
      r_ate        <= w_ate_n;
      r_food_valid <= w_food_valid_n;
      r_food_x     <= w_food_x_n;
      r_food_y     <= w_food_y_n;
      r_score      <= w_score_n;
    end
  end

  assign update     = r_update;
  assign ate        = r_ate;
  assign food_valid = r_food_valid;
  assign food_X     = r_food_x;
  assign food_Y     = r_food_y;
  assign score      = r_score;

endmodule

// File: tb/tb_food_tracker.sv
// Scoreboard bench for food_tracker: stimulus pushes expected ate/commit
// events; a negedge monitor pops and compares when the DUT presents them.
module tb_food_tracker;

  logic       VGA_clk;
  logic       reset;
  logic       frame_tick;
  logic [9:0] head_X;
  logic [8:0] head_Y;
  logic [9:0] rand_X = 10'd70;
  logic [8:0] rand_Y = 9'd90;
  logic       update;
  logic [9:0] food_X;
  logic [8:0] food_Y;
  logic       food_valid;
  logic       ate;
  logic [7:0] score;

  food_tracker dut (
    .VGA_clk    (VGA_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .head_X     (head_X),
    .head_Y     (head_Y),
    .rand_X     (rand_X),
    .rand_Y     (rand_Y),
    .update     (update),
    .food_X     (food_X),
    .food_Y     (food_Y),
    .food_valid (food_valid),
    .ate        (ate),
    .score      (score)
  );

  typedef struct {
    logic       commit;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  logic [18:0] cand_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          upd_rises = 0;
  logic        prev_fv = 1'b0, prev_ate = 1'b0, prev_upd = 1'b0, gen_prev = 1'b0;
  logic [9:0]  cur_fx;
  logic [8:0]  cur_fy;

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic push_ate(input logic [7:0] sc);
    exp_t e;
    e.commit = 1'b0; e.x = '0; e.y = '0; e.sc = sc;
    exp_q.push_back(e);
  endtask

  task automatic push_commit(input logic [9:0] x, input logic [8:0] y, input logic [7:0] sc);
    exp_t e;
    e.commit = 1'b1; e.x = x; e.y = y; e.sc = sc;
    exp_q.push_back(e);
  endtask

  // Generator model: new candidate on each rising edge of update
  always @(negedge VGA_clk) begin
    if (update && !gen_prev && cand_q.size() > 0) {rand_X, rand_Y} = cand_q.pop_front();
    gen_prev = update;
  end

  // Monitor: compare DUT events against the scoreboard
  always @(negedge VGA_clk) begin
    exp_t e;
    if (!reset) begin
      if (food_valid && !prev_fv) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_commit_unexpected: got commit (%0d,%0d) want none", food_X, food_Y);
        end else begin
          e = exp_q.pop_front();
          chk("commit_kind", 32'(e.commit), 32'd1);
          chk("commit_x", 32'(food_X), 32'(e.x));
          chk("commit_y", 32'(food_Y), 32'(e.y));
          chk("commit_score", 32'(score), 32'(e.sc));
        end
      end
      if (ate) begin
        chk("ate_width", 32'(prev_ate), 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_ate_unexpected: got ate score %0h want none", score);
        end else begin
          e = exp_q.pop_front();
          chk("ate_kind", 32'(e.commit), 32'd0);
          chk("ate_score", 32'(score), 32'(e.sc));
          chk("ate_fv", 32'(food_valid), 32'd0);
          chk("ate_update", 32'(update), 32'd1);
        end
      end
    end
    if (update && !prev_upd) upd_rises++;
    prev_fv  <= food_valid;
    prev_ate <= ate;
    prev_upd <= update;
  end

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_fv(input int budget);
    int k;
    k = 0;
    while (!food_valid && k < budget) begin
      @(negedge VGA_clk);
      k++;
    end
    if (!food_valid) begin
      n_vec++; n_err++;
      $display("FAIL fv_timeout: got food_valid 0 want 1 within %0d cycles", budget);
    end
  endtask

  task automatic no_hit(input logic [9:0] hx, input logic [8:0] hy, input logic [7:0] sc);
    int r0;
    r0 = upd_rises;
    head_X = hx; head_Y = hy;
    pulse_tick();
    repeat (8) @(negedge VGA_clk);
    chk("nohit_score", 32'(score), 32'(sc));
    chk("nohit_rises", 32'(upd_rises), 32'(r0));
    chk("nohit_fv", 32'(food_valid), 32'd1);
  endtask

  task automatic do_hit(input logic [9:0] hx, input logic [8:0] hy, input logic [7:0] sc,
                        input logic [9:0] cx, input logic [8:0] cy);
    head_X = hx; head_Y = hy;
    cand_q.push_back({cx, cy});
    push_ate(sc);
    push_commit(cx, cy, sc);
    pulse_tick();
    wait_fv(60);
    cur_fx = cx; cur_fy = cy;
  endtask

  initial begin
    logic       exp_upd [6];
    logic       exp_fv  [6];
    logic [7:0] sc;
    int         r0;
    exp_upd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_fv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; frame_tick = 1'b0;
    head_X = 10'd300; head_Y = 9'd200;
    repeat (3) @(negedge VGA_clk);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_ate", 32'(ate), 32'd0);
    chk("rst_fv", 32'(food_valid), 32'd0);
    chk("rst_food_x", 32'(food_X), 32'd0);
    chk("rst_food_y", 32'(food_Y), 32'd0);
    chk("rst_score", 32'(score), 32'h00);

    // Release reset: first commit one edge later, no update
    push_commit(10'd70, 9'd90, 8'h00);
    reset = 1'b0;
    @(negedge VGA_clk);
    chk("post_rst_fv", 32'(food_valid), 32'd1);
    chk("post_rst_fx", 32'(food_X), 32'd70);
    chk("post_rst_rises", 32'(upd_rises), 32'd0);

    // Hit with exact cycle-by-cycle timing
    head_X = 10'd75; head_Y = 9'd95;
    cand_q.push_back({10'd400, 9'd300});
    push_ate(8'h01);
    push_commit(10'd400, 9'd300, 8'h01);
    pulse_tick();
    for (int i = 0; i < 6; i++) begin
      chk("seq_update", 32'(update), 32'(exp_upd[i]));
      chk("seq_fv", 32'(food_valid), 32'(exp_fv[i]));
      chk("seq_ate", 32'(ate), (i == 0) ? 32'd1 : 32'd0);
      @(negedge VGA_clk);
    end
    chk("seq_food_x", 32'(food_X), 32'd400);
    chk("seq_food_y", 32'(food_Y), 32'd300);
    cur_fx = 10'd400; cur_fy = 9'd300;

    // Collision window edges on both sides
    no_hit(10'd410, 9'd300, 8'h01);
    no_hit(10'd390, 9'd300, 8'h01);
    do_hit(10'd391, 9'd300, 8'h02, 10'd70, 9'd90);
    no_hit(10'd80, 9'd90, 8'h02);

    // Three overlapping candidates rejected, fourth committed anyway
    r0 = upd_rises;
    head_X = 10'd79; head_Y = 9'd90;
    cand_q.push_back({10'd79, 9'd90});
    cand_q.push_back({10'd75, 9'd95});
    cand_q.push_back({10'd85, 9'd85});
    cand_q.push_back({10'd79, 9'd90});
    push_ate(8'h03);
    push_commit(10'd79, 9'd90, 8'h03);
    pulse_tick();
    wait_fv(100);
    chk("reroll_rises", 32'(upd_rises - r0), 32'd4);
    cur_fx = 10'd79; cur_fy = 9'd90;

    // Score through 09->10 and saturation at 99
    for (int n = 4; n <= 100; n++) begin
      sc = {4'((n > 99 ? 99 : n) / 10), 4'((n > 99 ? 99 : n) % 10)};
      if (n[0]) do_hit(cur_fx, cur_fy, sc, 10'd100, 9'd100);
      else      do_hit(cur_fx, cur_fy, sc, 10'd500, 9'd400);
    end
    chk("sat_score", 32'(score), 32'h99);

    // Reset during the second update-high cycle
    head_X = cur_fx; head_Y = cur_fy;
    cand_q.push_back({10'd123, 9'd45});
    push_ate(8'h99);
    pulse_tick();
    @(negedge VGA_clk);
    chk("mid_update_hi", 32'(update), 32'd1);
    reset = 1'b1;
    @(negedge VGA_clk);
    chk("mid_rst_update", 32'(update), 32'd0);
    chk("mid_rst_score", 32'(score), 32'h00);
    chk("mid_rst_fv", 32'(food_valid), 32'd0);
    chk("mid_rst_ate", 32'(ate), 32'd0);
    push_commit(10'd123, 9'd45, 8'h00);
    reset = 1'b0;
    @(negedge VGA_clk);
    chk("restart_fv", 32'(food_valid), 32'd1);
    chk("restart_fx", 32'(food_X), 32'd123);
    chk("restart_fy", 32'(food_Y), 32'd45);

    repeat (3) @(negedge VGA_clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
